// File: rtl/hex_digit_driver.sv
// rtl/hex_digit_driver.sv - seven-segment driver for one HEX PIO digit
//
// Purpose: decodes the nibble latched from a HEX PIO out_port and drives one
//   seven-segment digit with decimal point, blank, blink and lamp-test control.
//   A free-running blink timebase is restarted whenever the latched value
//   changes, so a freshly written value is always shown lit first.
//
// Ports:
//   clk          in   1  system clock (HEX PIO domain)
//   reset_n      in   1  asynchronous active-low reset
//   pio_data     in   8  [3:0] digit, [4] dp, [5] blink en, [6] blank, [7] ignored
//   lamp_test    in   1  forces every segment and dp lit
//   hex_seg      out  7  segments g..a, registered, polarity per SEG_ACTIVE_LOW
//   hex_dp       out  1  decimal point, registered, same polarity
//   blink_phase  out  1  1 = ON half, 0 = OFF half of the blink period
//   data_changed out  1  one-cycle pulse when pio_data[6:0] differs from the latch
module hex_digit_driver #(
  parameter int BLINK_HALF_CYCLES = 12_500_000,
  parameter bit SEG_ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pio_data,
  input  logic       lamp_test,
  output logic [6:0] hex_seg,
  output logic       hex_dp,
  output logic       blink_phase,
  output logic       data_changed
);

  localparam int CW = (BLINK_HALF_CYCLES > 2) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF_CYCLES - 1);
  // XOR mask that turns an active-high pattern into pin polarity
  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};

  logic [6:0]    data_q;
  logic          chg;
  logic [CW-1:0] blink_cnt;
  logic [6:0]    seg_decoded;
  logic [6:0]    seg_lit;
  logic          dp_lit;

  // Stage 1: latch the meaningful bits; bit 7 never reaches the compare
  assign chg = (pio_data[6:0] != data_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= 7'h00;
      data_changed <= 1'b0;
    end else begin
      data_q       <= pio_data[6:0];
      data_changed <= chg;
    end
  end

  // Blink timebase; a change restarts it in the ON half, overriding any
  // terminal count that happens to fall in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (data_changed) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Hex decode, active-high gfedcba
  always_comb begin
    seg_decoded = 7'h00;
    case (data_q[3:0])
      4'h0: seg_decoded = 7'h3F;
      4'h1: seg_decoded = 7'h06;
      4'h2: seg_decoded = 7'h5B;
      4'h3: seg_decoded = 7'h4F;
      4'h4: seg_decoded = 7'h66;
      4'h5: seg_decoded = 7'h6D;
      4'h6: seg_decoded = 7'h7D;
      4'h7: seg_decoded = 7'h07;
      4'h8: seg_decoded = 7'h7F;
      4'h9: seg_decoded = 7'h6F;
      4'hA: seg_decoded = 7'h77;
      4'hB: seg_decoded = 7'h7C;
      4'hC: seg_decoded = 7'h39;
      4'hD: seg_decoded = 7'h5E;
      4'hE: seg_decoded = 7'h79;
      4'hF: seg_decoded = 7'h71;
      default: seg_decoded = 7'h00;
    endcase
  end

  // Output priority: lamp test, blank, blink-off, normal decode
  always_comb begin
    seg_lit = 7'h00;
    dp_lit  = 1'b0;
    if (lamp_test) begin
      seg_lit = 7'h7F;
      dp_lit  = 1'b1;
    end else if (data_q[6]) begin
      seg_lit = 7'h00;
      dp_lit  = 1'b0;
    end else if (data_q[5] && !blink_phase) begin
      seg_lit = 7'h00;
      dp_lit  = 1'b0;
    end else begin
      seg_lit = seg_decoded;
      dp_lit  = data_q[4];
    end
  end

  // Stage 2: pin registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_seg <= SEG_POL;
      hex_dp  <= SEG_ACTIVE_LOW;
    end else begin
      hex_seg <= seg_lit ^ SEG_POL;
      hex_dp  <= dp_lit ^ SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_hex_digit_driver.sv
// tb/tb_hex_digit_driver.sv - self-checking bench for hex_digit_driver
module tb_hex_digit_driver;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pio_data = 8'h00;
  logic       lamp_test = 1'b0;
  logic [6:0] hex_seg;
  logic       hex_dp;
  logic       blink_phase;
  logic       data_changed;

  int errors = 0;
  int checks = 0;

  hex_digit_driver #(.BLINK_HALF_CYCLES(H), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .pio_data(pio_data), .lamp_test(lamp_test),
    .hex_seg(hex_seg), .hex_dp(hex_dp), .blink_phase(blink_phase),
    .data_changed(data_changed)
  );

  always #5 clk = ~clk;

  // Reference model: pins derived from the latched value, the age since the
  // last restart and the lamp-test input, using plain arithmetic.
  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] m_data;
  logic       m_changed;
  int         m_age;
  logic [6:0] m_seg;
  logic       m_dp;

  function automatic logic phase_of(int age);
    return ((age / H) % 2) == 0;
  endfunction

  function automatic logic [7:0] pins_of(logic [6:0] d, logic ph, logic lt);
    logic [6:0] s;
    logic p;
    if (lt) begin s = 7'h7F; p = 1'b1; end
    else if (d[6] || (d[5] && !ph)) begin s = 7'h00; p = 1'b0; end
    else begin s = dec_tab[d[3:0]]; p = d[4]; end
    return {~p, ~s};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= 7'h00; m_changed <= 1'b0; m_age <= 0; m_seg <= 7'h7F; m_dp <= 1'b1;
    end else begin
      m_data    <= pio_data[6:0];
      m_changed <= (pio_data[6:0] != m_data);
      m_age     <= m_changed ? 0 : m_age + 1;
      {m_dp, m_seg} <= pins_of(m_data, phase_of(m_age), lamp_test);
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; pio_data = 8'h00; lamp_test = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({hex_seg, hex_dp, blink_phase, data_changed} !== {7'h7F, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got seg=%h dp=%b ph=%b chg=%b, want seg=7f dp=1 ph=1 chg=0",
               hex_seg, hex_dp, blink_phase, data_changed);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (hex_seg !== 7'h40 || hex_dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_zero: got seg=%h dp=%b, want seg=40 dp=1", hex_seg, hex_dp);
    end
  endtask

  task automatic test_decode_dp();
    pio_data = 8'h18;
    @(negedge clk);
    checks++;
    if (data_changed !== 1'b1) begin
      errors++; $display("FAIL dp_change_pulse: got %b want 1", data_changed);
    end
    @(negedge clk);
    checks++;
    if ({data_changed, hex_seg, hex_dp} !== {1'b0, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL dp_decode_8: got chg=%b seg=%h dp=%b want chg=0 seg=00 dp=0",
               data_changed, hex_seg, hex_dp);
    end
  endtask

  task automatic test_blink();
    int bound;
    pio_data = 8'h2A;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({hex_seg, hex_dp, blink_phase, data_changed} !== {m_seg, m_dp, phase_of(m_age), m_changed}) begin
        errors++;
        $display("FAIL blink_cycle%0d: got seg=%h dp=%b ph=%b chg=%b want seg=%h dp=%b ph=%b chg=%b",
                 i, hex_seg, hex_dp, blink_phase, data_changed, m_seg, m_dp, phase_of(m_age), m_changed);
      end
    end
    bound = 0;
    while (blink_phase !== 1'b0 && bound < 10) begin
      @(negedge clk); bound++;
    end
    checks++;
    if (blink_phase !== 1'b0) begin
      errors++; $display("FAIL blink_off_wait: phase=%b want 0 within 10 clk", blink_phase);
    end
    pio_data = 8'h2B;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (data_changed !== 1'b1) begin
          errors++; $display("FAIL rewrite_pulse: got %b want 1", data_changed);
        end
      end
      if (k == 2) begin
        checks++;
        if (blink_phase !== 1'b1) begin
          errors++; $display("FAIL rewrite_phase_on: got %b want 1", blink_phase);
        end
      end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (hex_seg !== 7'h03) begin
          errors++; $display("FAIL rewrite_lit_k%0d: got seg=%h want 03", k, hex_seg);
        end
      end
      if (k == 7) begin
        checks++;
        if (hex_seg !== 7'h7F) begin
          errors++; $display("FAIL rewrite_off_after: got seg=%h want 7f", hex_seg);
        end
      end
    end
  endtask

  task automatic test_blank_lamp();
    pio_data = 8'h45;
    repeat (2) @(negedge clk);
    checks++;
    if (hex_seg !== 7'h7F || hex_dp !== 1'b1) begin
      errors++; $display("FAIL blank: got seg=%h dp=%b want seg=7f dp=1", hex_seg, hex_dp);
    end
    lamp_test = 1'b1;
    @(negedge clk);
    checks++;
    if (hex_seg !== 7'h00 || hex_dp !== 1'b0) begin
      errors++; $display("FAIL lamp_test: got seg=%h dp=%b want seg=00 dp=0", hex_seg, hex_dp);
    end
    lamp_test = 1'b0;
    @(negedge clk);
    checks++;
    if (hex_seg !== 7'h7F) begin
      errors++; $display("FAIL lamp_release: got seg=%h want 7f", hex_seg);
    end
  endtask

  task automatic test_bit7();
    pio_data = 8'h05;
    repeat (3) @(negedge clk);
    pio_data = 8'h85;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (data_changed !== 1'b0 || hex_seg !== 7'h12) begin
        errors++;
        $display("FAIL bit7_ignored%0d: got chg=%b seg=%h want chg=0 seg=12", i, data_changed, hex_seg);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pio_data = 8'($urandom);
      lamp_test = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      checks++;
      if ({hex_seg, hex_dp, blink_phase, data_changed} !== {m_seg, m_dp, phase_of(m_age), m_changed}) begin
        errors++;
        $display("FAIL random_cycle%0d: got seg=%h dp=%b ph=%b chg=%b want seg=%h dp=%b ph=%b chg=%b",
                 i, hex_seg, hex_dp, blink_phase, data_changed, m_seg, m_dp, phase_of(m_age), m_changed);
      end
    end
    lamp_test = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      pio_data = {1'b0, 2'b01, 1'b0, 4'(i)};
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (data_changed !== 1'b1 || (i > 1 && blink_phase !== 1'b1)) begin
          errors++;
          $display("FAIL back_to_back%0d: got chg=%b ph=%b want chg=1 ph=1", i, data_changed, blink_phase);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    pio_data = 8'h2A;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({hex_seg, hex_dp, blink_phase, data_changed} !== {7'h7F, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got seg=%h dp=%b ph=%b chg=%b want seg=7f dp=1 ph=1 chg=0",
               hex_seg, hex_dp, blink_phase, data_changed);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({hex_seg, hex_dp, blink_phase, data_changed} !== {m_seg, m_dp, phase_of(m_age), m_changed}) begin
        errors++;
        $display("FAIL after_reset%0d: got seg=%h ph=%b chg=%b want seg=%h ph=%b chg=%b",
                 i, hex_seg, blink_phase, data_changed, m_seg, phase_of(m_age), m_changed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode_dp();
    test_blink();
    test_blank_lamp();
    test_bit7();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
